pixel_streamer: RTL

- Transmit end of the raster pixel stream consumed by the CNN 3x3 windowing stage.
- On `start`, reads one IMG_WIDTH x IMG_HEIGHT 8-bit image from a synchronous frame memory (1-cycle read latency).
- Emits the pixels in row-major order over a valid/ready stream, with sof/eol/eof side flags.
- Full rate of 1 pixel/cycle while ready is held; a 2-entry output FIFO absorbs backpressure.

---
 rtl/pixel_streamer_if.sv | 33 +++
 rtl/pixel_streamer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pixel_streamer_if.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | pixel_streamer_if : frame-memory read port and pixel stream       |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
interface pixel_streamer_if #(
   parameter int ADDR_W = 10
);
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rd_data;
   logic [7:0]        pixel_out;
   logic              pixel_valid;
   logic              pixel_ready;
   logic              sof;
   logic              eol;
   logic              eof;

   modport master (
      output mem_rd_en, mem_addr,
      input  mem_rd_data,
      output pixel_out, pixel_valid, sof, eol, eof,
      input  pixel_ready
   );

   modport slave (
      input  mem_rd_en, mem_addr,
      output mem_rd_data,
      input  pixel_out, pixel_valid, sof, eol, eof,
      output pixel_ready
   );
endinterface
`default_nettype wire

// File: rtl/pixel_streamer.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | pixel_streamer : reads one frame from memory, streams it raster   |
// | order with sof/eol/eof through a 2-entry FIFO.  Rev 1.0           |
// +-------------------------------------------------------------------+
module pixel_streamer #(
   parameter int IMG_WIDTH  = 28,
   parameter int IMG_HEIGHT = 28,
   parameter int ADDR_W     = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic busy,
   output logic done,
   pixel_streamer_if.master bus
);
   localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
   localparam int CW    = $clog2(TOTAL + 1);
   localparam int COL_W = $clog2(IMG_WIDTH + 1);
   localparam int ROW_W = $clog2(IMG_HEIGHT + 1);
   localparam logic [CW-1:0]    TOTAL_CNT = CW'(TOTAL);
   localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_HEIGHT - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [CW-1:0]    r_cnt;
   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   logic             r_inflight;
   logic [2:0]       r_pend_flags;
   logic [10:0]      r_fifo [2];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;
   logic [10:0]      w_head;
   logic [1:0]       w_occ;
   logic             w_push;
   logic             w_pop;
   logic             w_valid;
   logic             w_rd_en;
   logic             w_sof;
   logic             w_eol;
   logic             w_eof;

   assign w_valid = (r_count != 2'd0);
   assign w_pop   = w_valid & bus.pixel_ready;
   assign w_push  = r_inflight;
   // occupancy the FIFO would have next cycle if no new read were issued
   assign w_occ   = r_count + {1'b0, r_inflight} - {1'b0, w_pop};
   assign w_rd_en = (r_state == S_RUN) && (r_cnt < TOTAL_CNT) && (w_occ < 2'd2);

   assign w_sof = (r_cnt == '0);
   assign w_eol = (r_col == LAST_COL);
   assign w_eof = w_eol && (r_row == LAST_ROW);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_next = S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            if (r_cnt == TOTAL_CNT) w_state_next = S_DRAIN;
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (!r_inflight && (r_count == 2'd0 || (r_count == 2'd1 && w_pop)))
               w_state_next = S_DONE;
         end
         S_DONE: begin
            done         = 1'b1;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || r_state == S_DONE || (r_state == S_IDLE && start)) begin
         r_cnt <= '0;
         r_col <= '0;
         r_row <= '0;
      end else if (w_rd_en) begin
         r_cnt <= r_cnt + 1'b1;
         if (w_eol) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   // flags travel with the read so they line up with the returning data
   always_ff @(posedge clk) begin
      if (rst) begin
         r_inflight   <= 1'b0;
         r_pend_flags <= 3'b000;
      end else begin
         r_inflight <= w_rd_en;
         if (w_rd_en) r_pend_flags <= {w_sof, w_eol, w_eof};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_fifo[r_wr_ptr] <= {bus.mem_rd_data, r_pend_flags};
   end

   assign w_head          = r_fifo[r_rd_ptr];
   assign bus.mem_rd_en   = w_rd_en;
   assign bus.mem_addr    = ADDR_W'(r_cnt);
   assign bus.pixel_valid = w_valid;
   assign bus.pixel_out   = w_valid ? w_head[10:3] : 8'd0;
   assign bus.sof         = w_valid & w_head[2];
   assign bus.eol         = w_valid & w_head[1];
   assign bus.eof         = w_valid & w_head[0];

   a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(w_push && !w_pop && r_count == 2'd2));

endmodule
`default_nettype wire
